// File: rtl/shift_operand_buffer.sv
// shift_operand_buffer
//   Two-entry in-order operand FIFO between decode and the shift unit.
//   It has a head register and a skid register. The head fields drive the
//   outputs directly. Entries with the illegal op code (3) are dropped, and
//   err_illegal_op pulses for one cycle when that happens.
//
// Ports
//   clk            rising-edge clock
//   rstn           synchronous active-low reset
//   flush          discard all buffered entries (and any push this cycle)
//   in_valid       upstream offers an entry
//   in_ready       buffer can accept an entry (count != 2)
//   in_a           operand a (rs1)
//   in_b           rs2 or immediate; only [4:0] is kept as shift amount
//   in_op          0 = SLL, 1 = SRL, 2 = SRA, 3 = illegal
//   out_valid      head entry available (count != 0)
//   out_ready      downstream consumes the head entry
//   out_a          head operand a
//   out_shamt      head shift amount
//   out_op         head op (0..2 only)
//   err_illegal_op one-cycle pulse after an illegal op was dropped
module shift_operand_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [4:0]       out_shamt,
    output logic [1:0]       out_op,
    output logic             err_illegal_op
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t occ, occ_next;

    logic [WIDTH-1:0] skid_a;
    logic [4:0]       skid_shamt;
    logic [1:0]       skid_op;

    logic in_fire, out_fire, push, illegal_drop;
    logic load_head_in, load_head_skid, load_skid_in;

    // Only the low five bits of in_b carry the shift amount.
    logic unused_b;
    assign unused_b = ^in_b[WIDTH-1:5];

    // Handshake flags depend only on registered occupancy.
    assign in_ready  = (occ != OCC_FULL);
    assign out_valid = (occ != OCC_EMPTY);

    assign in_fire      = in_valid & in_ready;
    assign out_fire     = out_valid & out_ready;
    assign push         = in_fire & (in_op != 2'd3) & ~flush;
    assign illegal_drop = in_fire & (in_op == 2'd3) & ~flush;

    always_ff @(posedge clk) begin
        if (!rstn) occ <= OCC_EMPTY;
        else       occ <= occ_next;
    end

    always_comb begin
        occ_next       = occ;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            occ_next = OCC_EMPTY;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        load_head_in = 1'b1;
                        occ_next     = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && out_fire) begin
                        // Replace the head in place: no bubble.
                        load_head_in = 1'b1;
                    end else if (push) begin
                        load_skid_in = 1'b1;
                        occ_next     = OCC_FULL;
                    end else if (out_fire) begin
                        occ_next = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (out_fire) begin
                        load_head_skid = 1'b1;
                        occ_next       = OCC_ONE;
                    end
                end
                default: occ_next = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_a          <= '0;
            out_shamt      <= '0;
            out_op         <= '0;
            skid_a         <= '0;
            skid_shamt     <= '0;
            skid_op        <= '0;
            err_illegal_op <= 1'b0;
        end else begin
            err_illegal_op <= illegal_drop;
            if (load_head_in) begin
                out_a     <= in_a;
                out_shamt <= in_b[4:0];
                out_op    <= in_op;
            end else if (load_head_skid) begin
                out_a     <= skid_a;
                out_shamt <= skid_shamt;
                out_op    <= skid_op;
            end
            if (load_skid_in) begin
                skid_a     <= in_a;
                skid_shamt <= in_b[4:0];
                skid_op    <= in_op;
            end
        end
    end

endmodule
